nfc_req_arbiter: RTL and testbench
==================================

NFC_REQ_ARBITER -- requirements
Module: nfc_req_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 2, the number of command requesters (2..4).
REQ-002 SHALL have parameter MAX_OUTST, default 8, the maximum number of commands issued but not yet done (1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock (XDMA domain); all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_valid, input, REQ_NUM bits: per-requester command valid.
REQ-006 SHALL have port o_ready, output, REQ_NUM bits: per-requester command accept.
REQ-007 SHALL have port i_opc, input, REQ_NUM*16 bits: opcodes; requester k occupies bits [16k+15:16k].
REQ-008 SHALL have port i_lba, input, REQ_NUM*48 bits: logical block addresses; requester k occupies bits [48k+47:48k].
REQ-009 SHALL have port i_len, input, REQ_NUM*24 bits: transfer lengths in bytes; requester k occupies bits [24k+23:24k].
REQ-010 SHALL have port req_fifo_almost_full, input, 1 bit: back-pressure from the channel request FIFO.
REQ-011 SHALL have port i_req_ready, input, 1 bit: channel request FIFO ready.
REQ-012 SHALL have port o_req_valid, output, 1 bit: channel request valid.
REQ-013 SHALL have port o_req_data, output, 264 bits: packed channel request.
REQ-014 SHALL have port i_done, input, 1 bit: one-cycle pulse marking completion of one command.
REQ-015 SHALL have port o_outst, output, 4 bits: current outstanding-command count.
REQ-016 SHALL have port o_busy, output, 1 bit: high when the state is not IDLE or o_outst is nonzero.
REQ-017 SHALL have port o_err, output, 1 bit: sticky flag for a done-count underflow.

Function
REQ-018 SHALL implement the two states IDLE and ISSUE.
REQ-019 SHALL, in IDLE, select grant g as the first requester with i_valid high, searching round-robin upward from pointer rr with wrap from REQ_NUM-1 to 0.
REQ-020 SHALL drive o_ready[g]=1 combinationally only when all of these hold: state is IDLE, a valid requester exists, req_fifo_almost_full=0, and o_outst<MAX_OUTST; all other o_ready bits SHALL be 0.
REQ-021 SHALL, on i_valid[g]&o_ready[g], register that requester's opc, lba and len together with g, and move to ISSUE.
REQ-022 SHALL assert o_req_valid in the cycle after the accept and hold o_req_valid and o_req_data stable until i_req_ready=1.
REQ-023 SHALL pack o_req_data as: [15:0] opc, [63:16] lba, [87:64] len, [91:88] g, [263:92] zero.
REQ-024 SHALL, on o_req_valid&i_req_ready, deassert o_req_valid, set rr to (g+1) mod REQ_NUM, increment o_outst, and return to IDLE.
REQ-025 SHALL give a peak throughput of one command per 2 cycles and a latency from requester accept to o_req_valid of 1 cycle.
REQ-026 SHALL not drop or withdraw a request already in ISSUE when req_fifo_almost_full rises; the signal blocks new grants only.
REQ-027 SHALL decrement o_outst on each i_done pulse.
REQ-028 SHALL leave o_outst unchanged when an increment and a decrement occur in the same cycle.
REQ-029 SHALL ignore i_done while o_outst=0, keep the count at 0, and set o_err=1; o_err SHALL stay set until reset.
REQ-030 SHALL grant no requester while o_outst=MAX_OUTST, so o_outst never exceeds MAX_OUTST.
REQ-031 SHALL ignore requesters with i_valid low; a requester that drops i_valid before being accepted loses no state.

Reset
REQ-032 SHALL, while rst_n=0, immediately force state=IDLE, rr=0, o_outst=0, o_err=0, o_req_valid=0, o_req_data=0, o_ready=0, and o_busy=0.
REQ-033 SHALL, if reset occurs mid-ISSUE, discard the pending request, and the first command after reset SHALL go to requester 0 when it is valid.

Verification
REQ-034 SHALL test this: after reset, requester 0 sends opc=0x0010, lba=0x123456789ABC, len=0x001000, with i_req_ready=1 -> o_ready[0] in the same cycle, o_req_valid 1 cycle later, o_req_data[91:0]=0x0_001000_123456789ABC_0010, o_outst=1.
REQ-035 SHALL test this: both requesters hold i_valid high continuously with i_req_ready=1 -> grant order 0,1,0,1, o_req_data[91:88] alternates 0/1, and one command issues every 2 cycles.
REQ-036 SHALL test this: i_req_ready=0 for 5 cycles while in ISSUE -> o_req_valid and o_req_data stay stable for all 5 cycles, and the command is accepted on the first cycle with i_req_ready=1.
REQ-037 SHALL test this: 8 commands issued with no i_done -> o_outst=8 and o_ready=0; then one i_done pulse -> o_outst=7 and the next grant follows; an i_done coinciding with an issue keeps o_outst unchanged.
REQ-038 SHALL test this: req_fifo_almost_full=1 while requesters are valid -> no o_ready; raising it mid-ISSUE still completes the pending request.
REQ-039 SHALL test this: i_done with o_outst=0 -> o_outst stays 0 and o_err=1 until rst_n is pulsed; asserting rst_n mid-ISSUE -> o_req_valid=0 immediately.

Source files
------------

// File: rtl/nfc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nfc_req_arbiter
// Purpose  : Round-robin command arbiter feeding one channel request FIFO,
//            tracking commands issued but not yet completed.
// Revision : 1.0
// ============================================================================
module nfc_req_arbiter #(
   parameter int REQ_NUM   = 2,
   parameter int MAX_OUTST = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [REQ_NUM-1:0]      i_valid,
   output logic [REQ_NUM-1:0]      o_ready,
   input  logic [REQ_NUM*16-1:0]   i_opc,
   input  logic [REQ_NUM*48-1:0]   i_lba,
   input  logic [REQ_NUM*24-1:0]   i_len,
   input  logic                    req_fifo_almost_full,
   input  logic                    i_req_ready,
   output logic                    o_req_valid,
   output logic [263:0]            o_req_data,
   input  logic                    i_done,
   output logic [3:0]              o_outst,
   output logic                    o_busy,
   output logic                    o_err
);

   localparam int              c_idx_w     = (REQ_NUM > 2) ? 2 : 1;
   localparam logic [3:0]      c_max_outst = 4'(MAX_OUTST);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t               r_state;
   logic [c_idx_w-1:0]   r_rr;
   logic [c_idx_w-1:0]   r_gnt;
   logic [15:0]          r_opc;
   logic [47:0]          r_lba;
   logic [23:0]          r_len;

   logic [c_idx_w:0]     w_idx;
   logic                 w_found;
   logic [c_idx_w-1:0]   w_gnt;
   logic [15:0]          w_opc;
   logic [47:0]          w_lba;
   logic [23:0]          w_len;
   logic                 w_allow;
   logic                 w_accept;
   logic                 w_fire;
   logic                 w_dec;

   // First valid requester at or above the round-robin pointer, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         w_idx = {1'b0, r_rr} + (c_idx_w+1)'(i);
         if (w_idx >= (c_idx_w+1)'(REQ_NUM))
            w_idx = w_idx - (c_idx_w+1)'(REQ_NUM);
         if (!w_found && i_valid[w_idx[c_idx_w-1:0]]) begin
            w_found = 1'b1;
            w_gnt   = w_idx[c_idx_w-1:0];
         end
      end
   end

   always_comb begin
      w_opc = '0;
      w_lba = '0;
      w_len = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (w_gnt == c_idx_w'(k)) begin
            w_opc = i_opc[k*16 +: 16];
            w_lba = i_lba[k*48 +: 48];
            w_len = i_len[k*24 +: 24];
         end
      end
   end

   // Gated by rst_n so no requester sees an accept while reset is held.
   assign w_allow  = rst_n && (r_state == IDLE) && w_found &&
                     !req_fifo_almost_full && (o_outst < c_max_outst);
   assign o_ready  = w_allow ? ({{(REQ_NUM-1){1'b0}}, 1'b1} << w_gnt) : '0;
   assign w_accept = |(i_valid & o_ready);
   assign w_fire   = o_req_valid & i_req_ready;
   assign w_dec    = i_done && (o_outst != 4'd0);

   assign o_req_data = {172'd0, 4'(r_gnt), r_len, r_lba, r_opc};
   assign o_busy     = (r_state != IDLE) || (o_outst != 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr        <= '0;
         r_gnt       <= '0;
         r_opc       <= '0;
         r_lba       <= '0;
         r_len       <= '0;
         o_req_valid <= 1'b0;
         o_outst     <= 4'd0;
         o_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_opc       <= w_opc;
                  r_lba       <= w_lba;
                  r_len       <= w_len;
                  r_gnt       <= w_gnt;
                  o_req_valid <= 1'b1;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (w_fire) begin
                  o_req_valid <= 1'b0;
                  r_rr        <= (r_gnt == c_idx_w'(REQ_NUM-1)) ? '0 : r_gnt + 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Simultaneous issue and completion cancel out.
         if (w_fire && !w_dec)
            o_outst <= o_outst + 4'd1;
         else if (!w_fire && w_dec)
            o_outst <= o_outst - 4'd1;

         if (i_done && (o_outst == 4'd0))
            o_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nfc_req_arbiter.sv
`default_nettype none
// Testbench for nfc_req_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_nfc_req_arbiter;

   localparam int RN = 2;
   localparam int MO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    i_valid;
   logic [1:0]    o_ready;
   logic [31:0]   i_opc;
   logic [95:0]   i_lba;
   logic [47:0]   i_len;
   logic          af;
   logic          i_req_ready;
   logic          o_req_valid;
   logic [263:0]  o_req_data;
   logic          i_done;
   logic [3:0]    o_outst;
   logic          o_busy;
   logic          o_err;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit            m_pend;
   int            m_rr;
   int            m_outst;
   int            m_gnt;
   bit            m_err;
   logic [263:0]  m_data;

   nfc_req_arbiter #(.REQ_NUM(RN), .MAX_OUTST(MO)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .i_valid              (i_valid),
      .o_ready              (o_ready),
      .i_opc                (i_opc),
      .i_lba                (i_lba),
      .i_len                (i_len),
      .req_fifo_almost_full (af),
      .i_req_ready          (i_req_ready),
      .o_req_valid          (o_req_valid),
      .o_req_data           (o_req_data),
      .i_done               (i_done),
      .o_outst              (o_outst),
      .o_busy               (o_busy),
      .o_err                (o_err)
   );

   always #5 clk = ~clk;

   function automatic int model_pick();
      for (int i = 0; i < RN; i++) begin
         int k;
         k = (m_rr + i) % RN;
         if (i_valid[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [1:0] model_ready();
      int g;
      g = model_pick();
      if (rst_n && !m_pend && g >= 0 && !af && m_outst < MO) return 2'(1 << g);
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_pend  = 0;
      m_rr    = 0;
      m_outst = 0;
      m_gnt   = 0;
      m_err   = 0;
      m_data  = '0;
   endtask

   task automatic model_tick();
      int g;
      logic [1:0] rdy;
      rdy = model_ready();
      g   = model_pick();
      if (i_done) begin
         if (m_outst > 0) m_outst--;
         else m_err = 1;
      end
      if (m_pend && i_req_ready) begin
         m_pend = 0;
         m_outst++;
         m_rr = (m_gnt + 1) % RN;
      end else if (!m_pend && rdy != 2'b00) begin
         m_pend = 1;
         m_gnt  = g;
         m_data = {172'd0, 4'(g), i_len[g*24 +: 24], i_lba[g*48 +: 48], i_opc[g*16 +: 16]};
      end
   endtask

   task automatic cycle();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n       = 1'b0;
      i_valid     = '0;
      i_opc       = '0;
      i_lba       = '0;
      i_len       = '0;
      af          = 1'b0;
      i_req_ready = 1'b0;
      i_done      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n       = 1'b0;
      i_valid     = 2'b11;
      i_req_ready = 1'b1;
      i_done      = 1'b0;
      af          = 1'b0;
      i_opc = '0; i_lba = '0; i_len = '0;
      @(posedge clk);
      #1;
      checks++;
      if (o_ready !== 2'b00) begin
         failures++; $display("FAIL reset_ready: got %b expected 00", o_ready);
      end
      checks++;
      if (o_req_valid !== 1'b0 || o_req_data !== 264'd0) begin
         failures++; $display("FAIL reset_req: got valid=%b data=%h expected 0/0", o_req_valid, o_req_data);
      end
      checks++;
      if (o_outst !== 4'd0 || o_err !== 1'b0 || o_busy !== 1'b0) begin
         failures++; $display("FAIL reset_status: got outst=%0d err=%b busy=%b expected 0/0/0", o_outst, o_err, o_busy);
      end
   endtask

   task automatic test_single();
      logic [263:0] exp;
      exp = {172'd0, 92'h0_001000_123456789ABC_0010};
      reset_dut();
      i_valid     = 2'b01;
      i_opc[15:0] = 16'h0010;
      i_lba[47:0] = 48'h123456789ABC;
      i_len[23:0] = 24'h001000;
      i_req_ready = 1'b1;
      #1;
      checks++;
      if (o_ready !== 2'b01) begin
         failures++; $display("FAIL single_ready: got %b expected 01", o_ready);
      end
      cycle();
      i_valid = 2'b00;
      checks++;
      if (o_req_valid !== 1'b1 || o_req_data !== exp) begin
         failures++; $display("FAIL single_req: got valid=%b data=%h expected 1/%h", o_req_valid, o_req_data, exp);
      end
      checks++;
      if (o_busy !== 1'b1) begin
         failures++; $display("FAIL single_busy: got %b expected 1", o_busy);
      end
      cycle();
      checks++;
      if (o_req_valid !== 1'b0 || o_outst !== 4'd1) begin
         failures++; $display("FAIL single_done: got valid=%b outst=%0d expected 0/1", o_req_valid, o_outst);
      end
   endtask

   task automatic test_round_robin();
      int exp_g[4] = '{0, 1, 0, 1};
      logic [1:0]  er;
      logic [15:0] eopc;
      reset_dut();
      i_valid     = 2'b11;
      i_opc       = {16'hB001, 16'hA000};
      i_lba       = {48'h1111_2222_3333, 48'h4444_5555_6666};
      i_len       = {24'h000200, 24'h000100};
      i_req_ready = 1'b1;
      #1;
      for (int n = 0; n < 4; n++) begin
         er   = 2'b01 << exp_g[n];
         eopc = (exp_g[n] == 1) ? 16'hB001 : 16'hA000;
         checks++;
         if (o_ready !== er) begin
            failures++; $display("FAIL rr_grant%0d: got %b expected %b", n, o_ready, er);
         end
         cycle();
         checks++;
         if (o_req_valid !== 1'b1 || o_req_data[91:88] !== 4'(exp_g[n]) || o_req_data[15:0] !== eopc) begin
            failures++; $display("FAIL rr_issue%0d: got valid=%b g=%0d opc=%h expected 1/%0d/%h",
                                 n, o_req_valid, o_req_data[91:88], o_req_data[15:0], exp_g[n], eopc);
         end
         checks++;
         if (o_ready !== 2'b00) begin
            failures++; $display("FAIL rr_issue_ready%0d: got %b expected 00", n, o_ready);
         end
         cycle();
      end
      checks++;
      if (o_outst !== 4'd4) begin
         failures++; $display("FAIL rr_outst: got %0d expected 4", o_outst);
      end
   endtask

   task automatic test_backpressure();
      logic [263:0] exp;
      reset_dut();
      i_valid = 2'b10;
      i_opc   = {16'h00C3, 16'h0000};
      i_lba   = {48'hFEDC_BA98_7654, 48'h0};
      i_len   = {24'hABCDEF, 24'h0};
      exp     = {172'd0, 4'd1, 24'hABCDEF, 48'hFEDC_BA98_7654, 16'h00C3};
      #1;
      checks++;
      if (o_ready !== 2'b10) begin
         failures++; $display("FAIL bp_ready: got %b expected 10", o_ready);
      end
      cycle();
      i_valid = 2'b00;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (o_req_valid !== 1'b1 || o_req_data !== exp) begin
            failures++; $display("FAIL bp_hold%0d: got valid=%b data=%h expected 1/%h", c, o_req_valid, o_req_data, exp);
         end
         cycle();
      end
      i_req_ready = 1'b1;
      #1;
      cycle();
      checks++;
      if (o_req_valid !== 1'b0 || o_outst !== 4'd1) begin
         failures++; $display("FAIL bp_release: got valid=%b outst=%0d expected 0/1", o_req_valid, o_outst);
      end
   endtask

   task automatic test_outstanding();
      reset_dut();
      i_valid     = 2'b01;
      i_req_ready = 1'b1;
      #1;
      repeat (16) cycle();
      repeat (2) begin
         checks++;
         if (o_outst !== 4'd8 || o_ready !== 2'b00) begin
            failures++; $display("FAIL os_full: got outst=%0d ready=%b expected 8/00", o_outst, o_ready);
         end
         cycle();
      end
      i_done = 1'b1;
      cycle();
      i_done = 1'b0;
      checks++;
      if (o_outst !== 4'd7 || o_ready !== 2'b01) begin
         failures++; $display("FAIL os_done: got outst=%0d ready=%b expected 7/01", o_outst, o_ready);
      end
      cycle();
      i_done = 1'b1;
      cycle();
      i_done = 1'b0;
      checks++;
      if (o_outst !== 4'd7 || o_req_valid !== 1'b0) begin
         failures++; $display("FAIL os_both: got outst=%0d valid=%b expected 7/0", o_outst, o_req_valid);
      end
   endtask

   task automatic test_almost_full();
      reset_dut();
      i_valid = 2'b11;
      af      = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (o_ready !== 2'b00) begin
            failures++; $display("FAIL af_block%0d: got %b expected 00", c, o_ready);
         end
         cycle();
      end
      af = 1'b0;
      #1;
      cycle();
      af = 1'b1;
      cycle();
      checks++;
      if (o_req_valid !== 1'b1) begin
         failures++; $display("FAIL af_hold: got %b expected 1", o_req_valid);
      end
      i_req_ready = 1'b1;
      cycle();
      checks++;
      if (o_req_valid !== 1'b0 || o_outst !== 4'd1 || o_ready !== 2'b00) begin
         failures++; $display("FAIL af_complete: got valid=%b outst=%0d ready=%b expected 0/1/00", o_req_valid, o_outst, o_ready);
      end
   endtask

   task automatic test_err_reset();
      reset_dut();
      i_done = 1'b1;
      cycle();
      i_done = 1'b0;
      checks++;
      if (o_outst !== 4'd0 || o_err !== 1'b1) begin
         failures++; $display("FAIL err_set: got outst=%0d err=%b expected 0/1", o_outst, o_err);
      end
      repeat (3) cycle();
      checks++;
      if (o_err !== 1'b1) begin
         failures++; $display("FAIL err_sticky: got %b expected 1", o_err);
      end
      i_valid     = 2'b01;
      i_req_ready = 1'b1;
      #1;
      cycle();
      cycle();
      i_valid     = 2'b11;
      i_req_ready = 1'b0;
      #1;
      checks++;
      if (o_ready !== 2'b10) begin
         failures++; $display("FAIL err_rr: got %b expected 10", o_ready);
      end
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_req_valid !== 1'b0 || o_err !== 1'b0 || o_outst !== 4'd0 || o_busy !== 1'b0) begin
         failures++; $display("FAIL async_reset: got valid=%b err=%b outst=%0d busy=%b expected 0/0/0/0",
                              o_req_valid, o_err, o_outst, o_busy);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      #1;
      checks++;
      if (o_ready !== 2'b01) begin
         failures++; $display("FAIL post_reset_grant: got %b expected 01", o_ready);
      end
      cycle();
      checks++;
      if (o_req_valid !== 1'b1 || o_req_data[91:88] !== 4'd0) begin
         failures++; $display("FAIL post_reset_issue: got valid=%b g=%0d expected 1/0", o_req_valid, o_req_data[91:88]);
      end
   endtask

   task automatic test_random();
      reset_dut();
      for (int n = 0; n < 400; n++) begin
         i_valid     = 2'($urandom_range(0, 3));
         i_opc       = $urandom;
         i_lba       = {$urandom, $urandom, $urandom};
         i_len       = 48'({$urandom, $urandom});
         af          = ($urandom_range(0, 7) == 0);
         i_req_ready = ($urandom_range(0, 3) != 0);
         i_done      = ($urandom_range(0, 3) == 0);
         #1;
         checks++;
         if (o_ready !== model_ready()) begin
            failures++; $display("FAIL rand_ready@%0d: got %b expected %b", n, o_ready, model_ready());
         end
         checks++;
         if (o_req_valid !== m_pend || (m_pend && o_req_data !== m_data)) begin
            failures++; $display("FAIL rand_req@%0d: got valid=%b data=%h expected %b/%h", n, o_req_valid, o_req_data, m_pend, m_data);
         end
         checks++;
         if (o_outst !== 4'(m_outst) || o_err !== m_err || o_busy !== (m_pend || m_outst != 0)) begin
            failures++; $display("FAIL rand_status@%0d: got outst=%0d err=%b busy=%b expected %0d/%b/%b",
                                 n, o_outst, o_err, o_busy, m_outst, m_err, (m_pend || m_outst != 0));
         end
         cycle();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_outstanding();
      test_almost_full();
      test_err_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
`default_nettype wire
